// File: rtl/shift_readout_controller.sv
// shift_readout_controller
//
// Sequencer for a parallel-load / serial-out register shifter in the readout
// path. A start request parallel-loads LENGTH words into the shifter. The
// words are then presented one at a time over a valid/ready handshake, with
// a single shift strobe between words. After the last word is accepted, or
// on abort, the shifter is cleared and a one-cycle done pulse is issued.
//
// Ports
//   clk_i         system clock, rising edge
//   reset_ni      asynchronous active-low reset
//   start_i       load request, sampled only in IDLE
//   abort_i       terminate the readout (ignored in IDLE / DONE)
//   sr_data_i     shifter word 0
//   sr_set_o      shifter parallel-load strobe
//   sr_select_o   shifter load/shift select (1 = load)
//   sr_shift_o    shifter shift strobe
//   sr_clear_o    shifter clear (active high)
//   out_valid_o   out_data_o holds a valid word
//   out_ready_i   consumer accepts the word
//   out_data_o    presented word (combinational from sr_data_i)
//   out_index_o   index of the presented word, 0 = first
//   out_last_o    presented word is the last one
//   busy_o        controller is not idle
//   done_o        one-cycle completion pulse
//   aborted_o     qualifies done_o: the readout ended by abort
module shift_readout_controller #(
    parameter  int BITS   = 4,
    parameter  int LENGTH = 4,
    localparam int IDX_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [BITS-1:0]  sr_data_i,
    output logic             sr_set_o,
    output logic             sr_select_o,
    output logic             sr_shift_o,
    output logic             sr_clear_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [BITS-1:0]  out_data_o,
    output logic [IDX_W-1:0] out_index_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        STROBE  = 3'd2,
        PRESENT = 3'd3,
        SHIFT   = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             aborted_q, aborted_d;

    // Every output is a flop whose D input is decoded from the next state,
    // so the shifter strobes leave the block glitch-free.
    logic sr_set_q, sr_set_d;
    logic sr_select_q, sr_select_d;
    logic sr_shift_q, sr_shift_d;
    logic sr_clear_q, sr_clear_d;
    logic valid_q, valid_d;
    logic last_q, last_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        aborted_d = aborted_q;

        case (state_q)
            IDLE:    if (start_i) state_d = LOAD;
            LOAD:    state_d = STROBE;
            STROBE: begin
                state_d = PRESENT;
                idx_d   = '0;
            end
            PRESENT: begin
                if (out_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            SHIFT:   state_d = PRESENT;
            DONE: begin
                state_d   = IDLE;
                idx_d     = '0;
                aborted_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                idx_d     = '0;
                aborted_d = 1'b0;
            end
        endcase

        // Abort wins over a same-cycle handshake: the index is left where it
        // was, so the word on the bus is not counted as accepted.
        if (abort_i && (state_q inside {LOAD, STROBE, PRESENT, SHIFT})) begin
            state_d   = DONE;
            idx_d     = idx_q;
            aborted_d = 1'b1;
        end
    end

    always_comb begin
        sr_select_d = (state_d == LOAD) || (state_d == STROBE);
        sr_set_d    = (state_d == STROBE);
        sr_shift_d  = (state_d == SHIFT);
        sr_clear_d  = (state_d == DONE);
        valid_d     = (state_d == PRESENT);
        last_d      = (state_d == PRESENT) && (idx_d == LAST_IDX);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            aborted_q   <= 1'b0;
            sr_set_q    <= 1'b0;
            sr_select_q <= 1'b0;
            sr_shift_q  <= 1'b0;
            sr_clear_q  <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            aborted_q   <= aborted_d;
            sr_set_q    <= sr_set_d;
            sr_select_q <= sr_select_d;
            sr_shift_q  <= sr_shift_d;
            sr_clear_q  <= sr_clear_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sr_set_o    = sr_set_q;
    assign sr_select_o = sr_select_q;
    assign sr_shift_o  = sr_shift_q;
    assign sr_clear_o  = sr_clear_q;
    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;
    assign out_index_o = idx_q;
    assign out_data_o  = sr_data_i;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    // aborted_q is only ever set on the way into DONE and cleared on the way
    // out, so it is high exactly alongside done.
    assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_shift_readout_controller.sv
// Testbench for shift_readout_controller. Two instances (LENGTH=4 and
// LENGTH=1) are each connected to a behavioural shifter. A transaction-level
// model predicts every output on every cycle, and directed tests add literal
// expectations for the key timing points.
module tb_shift_readout_controller;

    localparam int P_IDLE = 0, P_LOAD = 1, P_STROBE = 2, P_PRESENT = 3, P_SHIFT = 4, P_DONE = 5;

    typedef struct {
        int phase;
        int idx;
        bit ab;
    } mst_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // ---------------- length = 4 instance ----------------
    logic       start4, abort4, ready4;
    logic [3:0] srd4, data4;
    logic       set4, sel4, shift4, clr4, vld4, last4, busy4, done4, abt4;
    logic [1:0] idx4;
    logic [3:0] pat4 [4] = '{4'h3, 4'h7, 4'hA, 4'hF};
    logic [3:0] sh4 [4];

    shift_readout_controller #(.BITS(4), .LENGTH(4)) dut4 (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start4), .abort_i(abort4),
        .sr_data_i(srd4), .sr_set_o(set4), .sr_select_o(sel4), .sr_shift_o(shift4),
        .sr_clear_o(clr4), .out_valid_o(vld4), .out_ready_i(ready4), .out_data_o(data4),
        .out_index_o(idx4), .out_last_o(last4), .busy_o(busy4), .done_o(done4),
        .aborted_o(abt4)
    );

    // ---------------- length = 1 instance ----------------
    logic       start1, abort1, ready1;
    logic [3:0] srd1, data1;
    logic       set1, sel1, shift1, clr1, vld1, last1, busy1, done1, abt1;
    logic [0:0] idx1;
    logic [3:0] pat1 = 4'h5;
    logic [3:0] sh1;

    shift_readout_controller #(.BITS(4), .LENGTH(1)) dut1 (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start1), .abort_i(abort1),
        .sr_data_i(srd1), .sr_set_o(set1), .sr_select_o(sel1), .sr_shift_o(shift1),
        .sr_clear_o(clr1), .out_valid_o(vld1), .out_ready_i(ready1), .out_data_o(data1),
        .out_index_o(idx1), .out_last_o(last1), .busy_o(busy1), .done_o(done1),
        .aborted_o(abt1)
    );

    // Behavioural shifters driven by the controller strobes.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) sh4[i] <= 4'h0;
            sh1 <= 4'h0;
        end else begin
            if (clr4) for (int i = 0; i < 4; i++) sh4[i] <= 4'h0;
            else if (set4 && sel4) for (int i = 0; i < 4; i++) sh4[i] <= pat4[i];
            else if (shift4 && !sel4) begin
                for (int i = 0; i < 3; i++) sh4[i] <= sh4[i+1];
                sh4[3] <= 4'h0;
            end
            if (clr1) sh1 <= 4'h0;
            else if (set1 && sel1) sh1 <= pat1;
        end
    end
    assign srd4 = sh4[0];
    assign srd1 = sh1;

    // Transaction-level model: where the readout is, and which word is up.
    function automatic mst_t step(input mst_t m, input int len, input bit st, input bit ab, input bit rdy);
        mst_t n = m;
        if (ab && m.phase inside {P_LOAD, P_STROBE, P_PRESENT, P_SHIFT}) begin
            n.phase = P_DONE; n.ab = 1'b1;
        end else begin
            case (m.phase)
                P_IDLE:   if (st) n.phase = P_LOAD;
                P_LOAD:   n.phase = P_STROBE;
                P_STROBE: begin n.phase = P_PRESENT; n.idx = 0; end
                P_PRESENT: if (rdy) begin
                    if (m.idx == len - 1) n.phase = P_DONE;
                    else begin n.phase = P_SHIFT; n.idx = m.idx + 1; end
                end
                P_SHIFT:  n.phase = P_PRESENT;
                default:  begin n.phase = P_IDLE; n.idx = 0; n.ab = 1'b0; end
            endcase
        end
        return n;
    endfunction

    // {busy, valid, last, select, set, shift, clear, done, aborted}
    function automatic logic [8:0] exp_flags(input mst_t m, input int len);
        exp_flags = {m.phase != P_IDLE, m.phase == P_PRESENT,
                     m.phase == P_PRESENT && m.idx == len - 1,
                     m.phase == P_LOAD || m.phase == P_STROBE, m.phase == P_STROBE,
                     m.phase == P_SHIFT, m.phase == P_DONE, m.phase == P_DONE,
                     m.phase == P_DONE && m.ab};
    endfunction

    mst_t m4, m1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m4 <= '{P_IDLE, 0, 1'b0};
            m1 <= '{P_IDLE, 0, 1'b0};
        end else begin
            m4 <= step(m4, 4, start4, abort4, ready4);
            m1 <= step(m1, 1, start1, abort1, ready1);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("flags4", int'({busy4, vld4, last4, sel4, set4, shift4, clr4, done4, abt4}), int'(exp_flags(m4, 4)));
        if (m4.phase == P_PRESENT || m4.phase == P_IDLE) check("index4", int'(idx4), m4.idx);
        if (m4.phase == P_PRESENT) check("data4", int'(data4), int'(pat4[m4.idx]));
        check("flags1", int'({busy1, vld1, last1, sel1, set1, shift1, clr1, done1, abt1}), int'(exp_flags(m1, 1)));
        if (m1.phase == P_PRESENT || m1.phase == P_IDLE) check("index1", int'(idx1), m1.idx);
        if (m1.phase == P_PRESENT) check("data1", int'(data1), int'(pat1));
    end

    // Strobe pulse counters (sampled at the edge they act on).
    int nsh4 = 0, nset4 = 0, nsh1 = 0;
    always @(posedge clk) begin
        if (shift4) nsh4++;
        if (set4)   nset4++;
        if (shift1) nsh1++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int vmask, lmask, dmask, s0, s1, k;
    logic [3:0] dat [16];
    logic [1:0] ix [16];

    initial begin
        start4 = 0; abort4 = 0; ready4 = 1;
        start1 = 0; abort1 = 0; ready1 = 1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("reset_outs4", int'({busy4, vld4, last4, sel4, set4, shift4, clr4, done4, abt4, idx4, data4}), 0);
        check("reset_outs1", int'({busy1, vld1, last1, sel1, set1, shift1, clr1, done1, abt1, idx1}), 0);

        // Full readout, ready tied high. Cycle n = interval after edge T+n-1.
        s0 = nsh4; s1 = nset4;
        start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        vmask = 0; lmask = 0; dmask = 0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            vmask |= int'(vld4) << n;
            lmask |= int'(last4) << n;
            dmask |= int'(done4) << n;
            dat[n] = data4;
            ix[n]  = idx4;
        end
        check("valid_cycles", vmask, (1 << 3) | (1 << 5) | (1 << 7) | (1 << 9));
        check("last_cycle", lmask, 1 << 9);
        check("done_cycle", dmask, 1 << 10);
        check("word0", int'({dat[3], ix[3]}), {4'h3, 2'd0});
        check("word1", int'({dat[5], ix[5]}), {4'h7, 2'd1});
        check("word2", int'({dat[7], ix[7]}), {4'hA, 2'd2});
        check("word3", int'({dat[9], ix[9]}), {4'hF, 2'd3});
        check("shift_pulses", nsh4 - s0, 3);
        check("set_pulses", nset4 - s1, 1);

        // Backpressure on word 1.
        @(negedge clk) start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        k = 0;
        while (!(vld4 && idx4 == 2'd1) && k < 20) begin @(negedge clk); k++; end
        check("bp_reach_word1", int'(vld4 && idx4 == 2'd1), 1);
        ready4 = 1'b0;
        s0 = nsh4;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold", int'({vld4, data4, idx4}), {1'b1, 4'h7, 2'd1});
            check("bp_no_shift", nsh4 - s0, 0);
        end
        ready4 = 1'b1;
        k = 0;
        while (!done4 && k < 20) begin @(negedge clk); k++; end
        check("bp_done", int'({done4, abt4}), 2'b10);
        @(negedge clk);

        // Abort while word 2 is on the bus with ready high.
        start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        k = 0;
        while (!(vld4 && idx4 == 2'd2) && k < 20) begin @(negedge clk); k++; end
        check("ab_reach_word2", int'(vld4 && idx4 == 2'd2), 1);
        abort4 = 1'b1;
        s0 = nsh4;
        @(negedge clk) abort4 = 1'b0;
        check("ab_done", int'({done4, abt4, clr4, idx4}), {3'b111, 2'd2});
        repeat (4) @(negedge clk);
        check("ab_no_shift", nsh4 - s0, 0);
        check("ab_idle", int'({busy4, abt4}), 0);

        // length = 1, with start pulses while busy.
        start1 = 1'b1; ready1 = 1'b0;
        @(negedge clk) start1 = 1'b0;
        k = 0;
        while (!vld1 && k < 20) begin @(negedge clk); k++; end
        check("l1_word", int'({vld1, last1, idx1, data1}), {3'b110, 4'h5});
        s0 = nsh1;
        start1 = 1'b1;
        repeat (2) @(negedge clk);
        start1 = 1'b0; ready1 = 1'b1;
        k = 0;
        while (!done1 && k < 20) begin @(negedge clk); k++; end
        check("l1_done", int'({done1, abt1}), 2'b10);
        check("l1_no_shift", nsh1 - s0, 0);
        repeat (3) begin
            @(negedge clk);
            check("l1_not_queued", int'(busy1), 0);
        end

        // Back-to-back with start held high.
        start4 = 1'b1;
        k = 0;
        while (!last4 && k < 20) begin @(negedge clk); k++; end
        check("b2b_last", int'(last4), 1);
        @(negedge clk);
        check("b2b_done", int'({done4, abt4}), 2'b10);
        @(negedge clk);
        check("b2b_idle", int'({busy4, abt4}), 0);
        @(negedge clk);
        check("b2b_reload", int'({busy4, sel4, set4, abt4}), 4'b1100);
        k = 0;
        while (!vld4 && k < 20) begin @(negedge clk); k++; end
        check("b2b_present", int'(vld4), 1);
        start4 = 1'b0;

        // Asynchronous reset in the middle of PRESENT.
        #2 reset_n = 1'b0;
        #1 check("async_reset4", int'({busy4, vld4, last4, sel4, set4, shift4, clr4, done4, abt4, idx4}), 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/shift_readout_controller.md
# shift_readout_controller

Sequencer for the parallel-load / serial-out register shifter in the readout path. On a `start` request it parallel-loads `length` words into the shifter and presents them one at a time over a valid/ready handshake, pulsing the shifter's `shift` strobe between words. When the last word is accepted it clears the shifter and pulses `done`. It sits between the frame/readout FSM (start/done) and the downstream word consumer (valid/ready).

## Interface
- `bits`, 4, width of one word; must match the shifter's `bits`
- `length`, 4, words per load; must match the shifter's `length`; legal range ≥ 1
- `IDX_W`, derived as max(1, clog2(`length`)), width of `out_index`

- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low; all state and outputs are forced to reset values while low
- `start`  in  1  load request; sampled only in IDLE
- `abort`  in  1  terminate the current readout; ignored in IDLE and DONE
- `sr_data`  in  `bits`  shifter `data_out` (word 0 of the shifter)
- `sr_set`  out  1  to shifter `set`
- `sr_select`  out  1  to shifter `set_select`
- `sr_shift`  out  1  to shifter `shift`
- `sr_clear`  out  1  to shifter `reset` (active-high)
- `out_valid`  out  1  `out_data` holds a valid word
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  `bits`  equals `sr_data`, passed through combinationally
- `out_index`  out  `IDX_W`  index of the presented word, 0 = first
- `out_last`  out  1  high with `out_valid` when `out_index` = `length`-1
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `aborted`  out  1  high together with `done` when the readout ended by `abort`

## Operation
- States: IDLE, LOAD, STROBE, PRESENT, SHIFT, DONE. Encoding is free.
- The shifter strobes (`sr_set`, `sr_select`, `sr_shift`, `sr_clear`) drive edge-triggered storage. Each must be driven straight from a flop, with no combinational decode after the state register.
- IDLE: all outputs 0. `start`=1 moves to LOAD.
- LOAD: `sr_select`=1, `sr_set`=0. `sr_select` settles one cycle before the `sr_set` edge. Next state is STROBE.
- STROBE: `sr_select`=1, `sr_set`=1, which gives the shifter its parallel-load edge. The word index resets to 0. Next state is PRESENT.
- PRESENT: `out_valid`=1 and `sr_select`=0.
  - On `out_valid`&`out_ready` with index < `length`-1: go to SHIFT and increment the index.
  - On acceptance with index = `length`-1: go to DONE.
  - Without `out_ready`: hold. `out_data` and `out_index` stay stable.
- SHIFT: `sr_shift`=1 for exactly one cycle, with `sr_select`=0 so the shifter shifts down by one word. `out_valid`=0. Next state is PRESENT.
- DONE: `done`=1 and `sr_clear`=1 for one cycle, with `aborted` as latched. Next state is IDLE, which clears `aborted`.
- `abort`=1 in LOAD, STROBE, PRESENT or SHIFT: next state is DONE with `aborted`=1.
  - `abort` has priority over a same-cycle handshake: that word is not counted as accepted.
- `out_last` = `out_valid` & (index = `length`-1).
- `length`=1: the first acceptance in PRESENT goes directly to DONE; SHIFT is never entered.
- The index never wraps. The maximum reached is `length`-1.

## Timing
- Reset (`reset`=0): state IDLE, every output 0, index 0, `aborted` 0. Deassertion takes effect at the next `clk` edge.
- Reset mid-readout: outputs drop to 0 immediately. This block does not clear the shifter; the system reset does.
- `start` high at edge T:
  - LOAD is active during cycle T+1.
  - STROBE is active during T+2.
  - First `out_valid` is at T+3.
- Handshake at edge P (not last): SHIFT during P+1, next word valid at P+2. Throughput is one word per 2 cycles.
- Last acceptance at edge P: `done` high during P+1, IDLE at P+2. `start` is accepted again at edge P+2.
- Minimum full readout with `out_ready` tied high is 2·`length`+2 cycles from `start` to `done`.
- `start` asserted while `busy`: ignored, not queued.

## Test plan
- Reset: hold `reset` low for 3 cycles, release. Expect all outputs 0. Pulse `reset` low mid-PRESENT: outputs return to 0 asynchronously.
- `length`=4, shifter loaded with 0x3,0x7,0xA,0xF, `out_ready`=1, `start` at cycle 0:
  - `out_data` sequence is 3,7,A,F with indices 0..3, at cycles 3,5,7,9.
  - `out_last` is high only at cycle 9.
  - `done` is high at cycle 10, with exactly 3 `sr_shift` pulses and 1 `sr_set` pulse.
- Backpressure: `out_ready` low for 5 cycles on word 1. `out_valid`, `out_data`=7 and `out_index`=1 are held stable, with no `sr_shift` until acceptance.
- Abort: `abort` in PRESENT with `out_ready`=1 on word 2. Next cycle `done`=1, `aborted`=1 and `sr_clear`=1. No further `sr_shift`, and no acceptance is counted for word 2.
- `length`=1: `start`, then accept once. `done` follows with zero `sr_shift` pulses. `start` asserted while `busy` has no effect.
- Back-to-back: `start` held high continuously. A second load begins exactly 2 cycles after the first acceptance of word 3, and `aborted` stays 0.
